// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file sequencer: opcodes,
// FSM states and instruction field positions.
package rf_seq_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_OUT = 4'hB;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;

    localparam int OPC_LO = 12;
    localparam int OPC_W  = 4;
    localparam int DA_LO  = 9;
    localparam int AA_LO  = 6;
    localparam int BA_LO  = 3;
    localparam int IMM_LO = 0;
    localparam int IMM_W  = 8;

    function automatic logic op_illegal(input logic [3:0] op);
        return op >= 4'hC;
    endfunction

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer: result, carry/borrow,
// signed overflow, plus register-write and flag-update qualifiers.
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]       op,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    input  logic [IMM_W-1:0] imm,
    output logic [DW-1:0]    res,
    output logic             c,
    output logic             v,
    output logic             wr,
    output logic             fl
);

    logic [DW:0] sum;
    logic [DW:0] dif;

    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        wr  = (op >= OP_MOV) && (op <= OP_LDI);
        fl  = (op >= OP_ADD) && (op <= OP_SHR);
        case (op)
            OP_MOV: res = a;
            OP_ADD: begin
                res = sum[DW-1:0];
                c   = sum[DW];
                v   = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
            end
            // dif[DW] is the borrow out, i.e. a < b unsigned
            OP_SUB: begin
                res = dif[DW-1:0];
                c   = dif[DW];
                v   = (a[DW-1] != b[DW-1]) && (dif[DW-1] != a[DW-1]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_SHL: begin
                res = {a[DW-2:0], 1'b0};
                c   = a[DW-1];
            end
            OP_SHR: begin
                res = {1'b0, a[DW-1:1]};
                c   = a[0];
            end
            OP_LDI: res = DW'(imm);
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/rf_sequencer.sv
// Four-state controller driving the register file: accept, read
// operands, execute, write back; one instruction per 4 cycles.
module rf_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    input  logic [15:0]   instr,
    output logic          instr_ready,
    output logic [AW-1:0] AA,
    output logic [AW-1:0] BA,
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    output logic [AW-1:0] DA,
    output logic [DW-1:0] Data,
    output logic          RW,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic [3:0]    flags,
    output logic          err
);

    state_e        state_q, state_d;
    logic [15:0]   instr_q, instr_d;
    logic [DW-1:0] opa_q, opa_d;
    logic [DW-1:0] opb_q, opb_d;
    logic [AW-1:0] da_q, da_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] out_q, out_d;
    logic [3:0]    flags_q, flags_d;

    logic [3:0]    opc;
    logic          accept;
    logic          in_wb;
    logic [DW-1:0] alu_res;
    logic          alu_c, alu_v, alu_wr, alu_fl;

    assign opc    = instr_q[OPC_LO +: OPC_W];
    assign accept = instr_valid && instr_ready;
    assign in_wb  = (state_q == WB) && !reset;

    rf_seq_alu #(.DW(DW)) u_alu (
        .op  (opc),
        .a   (opa_q),
        .b   (opb_q),
        .imm (instr_q[IMM_LO +: IMM_W]),
        .res (alu_res),
        .c   (alu_c),
        .v   (alu_v),
        .wr  (alu_wr),
        .fl  (alu_fl)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = READ;
            READ: state_d = EXEC;
            EXEC: state_d = WB;
            WB:   state_d = IDLE;
        endcase
    end

    // Strobes are gated by reset so nothing fires in the reset cycle
    always_comb begin
        instr_ready = (state_q == IDLE) && !reset;
        RW          = in_wb && alu_wr;
        out_valid   = in_wb && (opc == OP_OUT);
        err         = in_wb && op_illegal(opc);
    end

    always_comb begin
        instr_d = instr_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        da_d    = da_q;
        data_d  = data_q;
        out_d   = out_q;
        flags_d = flags_q;
        if (accept) instr_d = instr;
        if (state_q == READ) begin
            opa_d = A;
            opb_d = B;
        end
        if (state_q == EXEC) begin
            if (alu_fl)
                flags_d = {alu_res[DW-1], alu_res == '0, alu_c, alu_v};
            if (alu_wr) begin
                da_d   = instr_q[DA_LO +: AW];
                data_d = alu_res;
            end
            if (opc == OP_OUT) out_d = opa_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            da_q    <= '0;
            data_q  <= '0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            instr_q <= instr_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            da_q    <= da_d;
            data_q  <= data_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign AA       = instr_q[AA_LO +: AW];
    assign BA       = instr_q[BA_LO +: AW];
    assign DA       = da_q;
    assign Data     = data_q;
    assign out_data = out_q;
    assign flags    = flags_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Directed bench: rf_sequencer closed around a behavioral 8x8
// register file, table of instructions plus multi-cycle sequences.
module tb_rf_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rf_clr = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic [2:0]  AA, BA, DA;
    logic [7:0]  A, B, Data, out_data;
    logic        RW, out_valid, err;
    logic [3:0]  flags;

    logic [7:0]  rf [8];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rw_cnt  = 0;
    int out_cnt = 0;
    int err_cnt = 0;
    int hs_cnt  = 0;
    logic [7:0] last_out = '0;
    int         rw_cyc [$];
    logic [7:0] rw_dat [$];

    always #5 clk = ~clk;

    rf_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .AA          (AA),
        .BA          (BA),
        .A           (A),
        .B           (B),
        .DA          (DA),
        .Data        (Data),
        .RW          (RW),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .flags       (flags),
        .err         (err)
    );

    assign A = rf[AA];
    assign B = rf[BA];

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (RW) begin
            rf[DA] <= Data;
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (RW) begin
            rw_cnt++;
            rw_cyc.push_back(cyc);
            rw_dat.push_back(Data);
        end
        if (out_valid) begin
            out_cnt++;
            last_out = out_data;
        end
        if (err) err_cnt++;
        if (instr_valid && instr_ready) hs_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction and return once the FSM is back in IDLE
    task automatic run(input logic [15:0] w);
        int n;
        n = 0;
        instr = w;
        instr_valid = 1'b1;
        while (!instr_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_timeout", 32'(n >= 20), 0);
        tick();
        instr_valid = 1'b0;
        repeat (3) tick();
    endtask

    typedef struct {
        string      name;
        logic [15:0] w;
        int         chk;
        int         idx;
        logic [7:0] val;
        logic [3:0] fl;
        int         rw;
        int         er;
    } vec_t;

    vec_t vq [$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rw0, out0, err0, hs0, rwd0, n;
        // chk: 0 none, 1 register value, 2 out_data
        vq.push_back('{"ldi_r1",   16'hA27F, 1, 1, 8'h7F, 4'b0000, 1, 0});
        vq.push_back('{"ldi_r2",   16'hA401, 1, 2, 8'h01, 4'b0000, 1, 0});
        vq.push_back('{"add_r3",   16'h2650, 1, 3, 8'h80, 4'b1001, 1, 0});
        vq.push_back('{"out_r3",   16'hB0C0, 2, 0, 8'h80, 4'b1001, 0, 0});
        vq.push_back('{"ldi_r4",   16'hA805, 1, 4, 8'h05, 4'b1001, 1, 0});
        vq.push_back('{"sub_r5",   16'h3B20, 1, 5, 8'h00, 4'b0100, 1, 0});
        vq.push_back('{"sub_r6",   16'h3C20, 1, 6, 8'hFB, 4'b1010, 1, 0});
        vq.push_back('{"ldi_r1b",  16'hA281, 1, 1, 8'h81, 4'b1010, 1, 0});
        vq.push_back('{"shl_r2",   16'h8440, 1, 2, 8'h02, 4'b0010, 1, 0});
        vq.push_back('{"ldi_r3",   16'hA601, 1, 3, 8'h01, 4'b0010, 1, 0});
        vq.push_back('{"shr_r4",   16'h98C0, 1, 4, 8'h00, 4'b0110, 1, 0});
        vq.push_back('{"ill_d",    16'hDE00, 1, 7, 8'h00, 4'b0110, 0, 1});
        vq.push_back('{"and_r5",   16'h4A58, 1, 5, 8'h01, 4'b0000, 1, 0});
        vq.push_back('{"xor_r6",   16'h6C48, 1, 6, 8'h00, 4'b0100, 1, 0});
        vq.push_back('{"not_r7",   16'h7E40, 1, 7, 8'h7E, 4'b0000, 1, 0});
        vq.push_back('{"mov_r0",   16'h10C0, 1, 0, 8'h01, 4'b0000, 1, 0});
        vq.push_back('{"or_r2",    16'h5408, 1, 2, 8'h81, 4'b1000, 1, 0});
        vq.push_back('{"nop",      16'h0000, 0, 0, 8'h00, 4'b1000, 0, 0});

        repeat (2) tick();
        check("ready_in_reset", 32'(instr_ready), 0);
        check("rw_in_reset", 32'(RW), 0);
        reset  = 1'b0;
        rf_clr = 1'b0;
        #1;
        check("ready_after_reset", 32'(instr_ready), 1);
        check("reset_outputs",
              {AA, BA, DA, Data, RW, out_data, out_valid, err},
              32'h0);
        check("reset_flags", 32'(flags), 0);

        foreach (vq[i]) begin
            rw0  = rw_cnt;
            out0 = out_cnt;
            err0 = err_cnt;
            run(vq[i].w);
            check({vq[i].name, "_rw"}, rw_cnt - rw0, vq[i].rw);
            check({vq[i].name, "_err"}, err_cnt - err0, vq[i].er);
            check({vq[i].name, "_flags"}, 32'(flags), 32'(vq[i].fl));
            if (vq[i].chk == 1)
                check({vq[i].name, "_reg"}, 32'(rf[vq[i].idx]), 32'(vq[i].val));
            if (vq[i].chk == 2) begin
                check({vq[i].name, "_outcnt"}, out_cnt - out0, 1);
                check({vq[i].name, "_outdata"}, 32'(last_out), 32'(vq[i].val));
            end
            if (i == 2) begin
                check("rw_pulses_3", rw_cyc.size(), 3);
                check("rw_gap_1", rw_cyc[1] - rw_cyc[0], 4);
                check("rw_gap_2", rw_cyc[2] - rw_cyc[1], 4);
            end
        end

        // Illegal opcode E: err in WB, no write, ready back at t+4
        rw0  = rw_cnt;
        err0 = err_cnt;
        instr = 16'hEE00;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        instr_valid = 1'b0;
        check("ill_ready_t1", 32'(instr_ready), 0);
        tick();
        tick();
        check("ill_err_wb", 32'(err), 1);
        check("ill_rw_wb", 32'(RW), 0);
        tick();
        check("ill_ready_t4", 32'(instr_ready), 1);
        check("ill_err_cnt", err_cnt - err0, 1);
        check("ill_no_rw", rw_cnt - rw0, 0);
        check("ill_flags", 32'(flags), 32'b1000);
        check("ill_r7", 32'(rf[7]), 32'h7E);

        // Back-to-back with instr_valid held high
        run(16'hA201);
        hs0  = hs_cnt;
        rwd0 = rw_dat.size();
        instr = 16'h2248;
        instr_valid = 1'b1;
        n = 0;
        while (hs_cnt < hs0 + 3 && n < 40) begin
            tick();
            n++;
        end
        instr_valid = 1'b0;
        repeat (4) tick();
        check("b2b_handshakes", hs_cnt - hs0, 3);
        check("b2b_writes", rw_dat.size() - rwd0, 3);
        check("b2b_w1", 32'(rw_dat[rwd0]), 32'h02);
        check("b2b_w2", 32'(rw_dat[rwd0 + 1]), 32'h04);
        check("b2b_w3", 32'(rw_dat[rwd0 + 2]), 32'h08);
        check("b2b_r1", 32'(rf[1]), 32'h08);

        run(16'hAA80);
        run(16'h2D68);
        check("add_wrap_r6", 32'(rf[6]), 32'h00);
        check("add_wrap_flags", 32'(flags), 32'b0111);

        // Reset while ADD R7 is in EXEC
        rw0 = rw_cnt;
        instr = 16'h2E48;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        instr_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("rst_ready_low", 32'(instr_ready), 0);
        check("rst_rw_low", 32'(RW), 0);
        reset = 1'b0;
        #1;
        check("rst_ready_after", 32'(instr_ready), 1);
        check("rst_flags", 32'(flags), 0);
        repeat (4) tick();
        check("rst_no_rw", rw_cnt - rw0, 0);
        check("rst_r7", 32'(rf[7]), 32'h7E);
        check("rst_flags_hold", 32'(flags), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_sequencer.md
# rf_sequencer

Multi-cycle controller that drives the 8×8 register file as its initiator. It accepts 16-bit instructions over a valid/ready handshake and decodes each one. It then drives the read addresses (AA/BA), captures operands A/B, computes an ALU result, and writes it back through DA/Data/RW. It sits between the instruction source (testbench or future fetch unit) and the register file, closing the datapath loop.

## Interface
- DW, 8, data width; must match register-file width
- AW, 3, register address width (2^AW registers)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- instr_valid  in  1  instruction present on instr
- instr  in  16  instruction word
- instr_ready  out  1  block can accept an instruction; high only in IDLE and not in reset
- AA  out  AW  register-file A read address
- BA  out  AW  register-file B read address
- A  in  DW  register-file A read data, combinational from AA
- B  in  DW  register-file B read data, combinational from BA
- DA  out  AW  register-file write address
- Data  out  DW  register-file write data
- RW  out  1  register-file write enable, one-cycle pulse
- out_data  out  DW  result of OUT instruction
- out_valid  out  1  one-cycle pulse qualifying out_data
- flags  out  4  {N,Z,C,V}, registered
- err  out  1  one-cycle pulse on illegal opcode

## Operation
- Instruction format:
  - [15:12] opcode, [11:9] DA, [8:6] AA, [5:3] BA, [2:0] ignored.
  - LDI uses [7:0] as an immediate instead of AA/BA.
- Opcodes:
  - 0 NOP, 1 MOV (A), 2 ADD (A+B), 3 SUB (A−B), 4 AND, 5 OR, 6 XOR.
  - 7 NOT (~A), 8 SHL (A<<1), 9 SHR (A>>1 logical), A LDI (imm).
  - B OUT (out_data←A, no write).
  - C–F are illegal.
- FSM states:
  - IDLE → READ on instr_valid&&instr_ready; instr is latched.
  - READ drives AA/BA from the latched fields and captures A/B into operand registers at the end of the cycle.
  - EXEC computes the result and updates flags.
  - WB asserts RW for a writing opcode, pulses out_valid for OUT, or pulses err for an illegal opcode, then returns to IDLE.
- RW is asserted only for opcodes 1–A. NOP, OUT and illegal opcodes never write.
- Arithmetic is computed in DW+1 bits:
  - ADD: C = carry out.
  - SUB: C = borrow (A<B unsigned).
  - V = signed overflow for ADD/SUB.
  - Logic ops and NOT: C=0, V=0.
  - SHL: C=A[DW−1]. SHR: C=A[0]. Both set V=0.
- N = result[DW−1] and Z = (result==0) for opcodes 2–9.
- Flags are unchanged by NOP, MOV, LDI, OUT and illegal opcodes.
- AA/BA/DA/Data hold their last values outside the states that use them. RW, out_valid and err are 0 outside WB.

## Timing
- Reset values:
  - State IDLE.
  - AA=BA=DA=0, Data=0, RW=0, out_data=0, out_valid=0, err=0, flags=0.
  - instr_ready=0 while reset is high, 1 in the first cycle after reset.
- Latency and throughput:
  - Handshake in cycle t, READ t+1, EXEC t+2, WB t+3.
  - The register file commits on the edge ending t+3.
  - instr_ready returns high at t+4.
  - Throughput is one instruction per 4 cycles.
- Handshake:
  - instr is sampled only when both valid and ready are high.
  - instr_valid while ready is low is ignored; the source must hold it.
- Read-after-write: a dependent next instruction reads in READ at or after t+5, after the WB commit, so no forwarding is needed.
- Reset mid-operation: the FSM returns to IDLE on the next edge and the in-flight instruction is discarded. RW is never asserted during or in the cycle after reset. Flags are cleared.
- DA=AA=BA aliasing is legal; operands are captured before writeback.

## Structure
- Package rf_seq_pkg:
  - Opcode constants OP_NOP…OP_OUT.
  - State enum {IDLE, READ, EXEC, WB}.
  - Instruction field bit-position constants.
- Sub-module rf_seq_alu: combinational. Takes opcode, operands and immediate; returns result, C, V and a writes flag.
- The FSM, operand registers and output registers live in rf_sequencer.
- The bench instantiates rf_sequencer with the register file.

## Test plan
- Reset, then LDI R1←0x7F and LDI R2←0x01, then ADD R3←R1+R2, then OUT R3:
  - out_data=0x80, flags N=1 Z=0 C=0 V=1.
  - Exactly 3 RW pulses, each 4 cycles apart.
- LDI R4←0x05, then SUB R5←R4−R4:
  - R5=0, Z=1, C=0.
  - SUB R6←R0(0)−R4 gives 0xFB, C=1, N=1.
- SHL on 0x81 gives 0x02, C=1. SHR on 0x01 gives 0x00, C=1, Z=1.
- Illegal opcode 0xE:
  - err pulses in WB with no RW and flags unchanged.
  - instr_ready is high 4 cycles after the handshake.
- Hold instr_valid high continuously with back-to-back instructions:
  - Each is accepted exactly once, only in IDLE.
  - ADD R1←R1+R1 repeated three times from R1=1 yields 2, 4, 8 (read-after-write correct).
- Assert reset during EXEC of ADD R7←…:
  - No RW pulse, R7 unchanged, flags=0.
  - instr_ready high the cycle after reset deasserts.
